// File: rtl/tristate_bus_demux_pkg.sv
// ----------------------------------------------------------------------------
// tristate_demux_pkg
// Shared definitions for the tri-state bus demultiplexer:
//   - state_t   : switch sequencer states (RUN, DRAIN, DEAD, SWITCH)
//   - TA_CNT_W  : width of the turnaround dead-cycle counter
//   - sel_valid : true when a requested channel index exists
// ----------------------------------------------------------------------------
package tristate_demux_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        DEAD   = 2'd2,
        SWITCH = 2'd3
    } state_t;

    localparam int TA_CNT_W = 4;

    // A channel request is only honoured when it names an existing lane.
    function automatic logic sel_valid(input logic [7:0] sel, input int nout);
        return (int'(sel) < nout);
    endfunction

endpackage

// File: rtl/tristate_bus_demux_if.sv
// ----------------------------------------------------------------------------
// tristate_bus_demux_if
// Groups the shared-bus side and the per-channel output side of the demux.
//   bus_data/bus_valid/bus_ready : shared bus beat handshake
//   sel                          : requested destination channel
//   out_data/out_valid/out_ready : NOUT channel lanes (lane i = [i*WIDTH +: WIDTH])
//   active_sel/busy/err_x        : status
// Modports:
//   master : the environment (drives bus, sel and per-lane ready)
//   slave  : the demux itself
// ----------------------------------------------------------------------------
interface tristate_bus_demux_if #(
    parameter int WIDTH = 8,
    parameter int NOUT  = 2
);
    localparam int SELW = (NOUT > 1) ? $clog2(NOUT) : 1;

    logic [WIDTH-1:0]      bus_data;
    logic                  bus_valid;
    logic                  bus_ready;
    logic [SELW-1:0]       sel;
    logic [NOUT*WIDTH-1:0] out_data;
    logic [NOUT-1:0]       out_valid;
    logic [NOUT-1:0]       out_ready;
    logic [SELW-1:0]       active_sel;
    logic                  busy;
    logic                  err_x;

    modport master (
        output bus_data, bus_valid, sel, out_ready,
        input  bus_ready, out_data, out_valid, active_sel, busy, err_x
    );

    modport slave (
        input  bus_data, bus_valid, sel, out_ready,
        output bus_ready, out_data, out_valid, active_sel, busy, err_x
    );

endinterface

// File: rtl/tristate_bus_demux_hold_reg.sv
// ----------------------------------------------------------------------------
// demux_hold_reg
// Single-entry valid/ready holding register. A load and a drain may happen in
// the same cycle, giving full throughput. Stored data returns to zero when
// the entry drains without a replacement so an idle lane reads as zero.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_data, in_valid : beat to load (in_valid must already include in_ready)
//   in_ready          : entry can take a beat this cycle
//   out_data, out_valid, out_ready : held beat and its consumer handshake
// ----------------------------------------------------------------------------
module demux_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             full_r;
    logic [WIDTH-1:0] data_r;

    // Space exists when empty or when the current entry leaves this cycle.
    assign in_ready  = !full_r || out_ready;
    assign out_data  = data_r;
    assign out_valid = full_r;

    // Entry storage: load wins over drain, drain clears, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 1'b0;
            data_r <= '0;
        end else if (in_valid) begin
            full_r <= 1'b1;
            data_r <= in_data;
        end else if (full_r && out_ready) begin
            full_r <= 1'b0;
            data_r <= '0;
        end else begin
            full_r <= full_r;
            data_r <= data_r;
        end
    end

endmodule

// File: rtl/tristate_bus_demux.sv
// ----------------------------------------------------------------------------
// tristate_bus_demux
// Samples a shared tri-state bus and steers each accepted beat to one of NOUT
// channels through a single-entry holding register. Channel changes follow a
// break-before-make sequence RUN -> DRAIN -> DEAD (TURNAROUND cycles) ->
// SWITCH -> RUN, so at most one lane is ever valid and the new lane sees no
// beat until the old one has drained and the dead time has elapsed.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : tristate_bus_demux_if.slave (bus handshake, sel, lanes, status)
// Optional feature (macro TRISTATE_DEMUX_XCHECK_EN):
//   defined   : err_x becomes a sticky flag set when an accepted beat carries
//               X/Z bits; the beat is still forwarded.
//   undefined : err_x is tied low.
// ----------------------------------------------------------------------------
module tristate_bus_demux
    import tristate_demux_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NOUT       = 2,
    parameter int TURNAROUND = 1
) (
    input  logic               clk,
    input  logic               rst,
    tristate_bus_demux_if.slave bus
);

    localparam int SELW = (NOUT > 1) ? $clog2(NOUT) : 1;

    state_t                state_r;
    state_t                state_s;
    logic [TA_CNT_W-1:0]   cnt_r;
    logic [TA_CNT_W-1:0]   cnt_s;
    logic [SELW-1:0]       active_sel_r;
    logic [SELW-1:0]       active_sel_s;

    logic                  sel_ok_s;
    logic                  switch_req_s;
    logic                  lane_ready_s;
    logic                  hold_ready_s;
    logic                  accept_s;
    logic                  hold_valid_s;
    logic [WIDTH-1:0]      hold_data_s;

    // Only the connected lane's ready matters; the others are ignored.
    assign lane_ready_s = bus.out_ready[active_sel_r];

    // Out-of-range requests behave as if sel matched active_sel.
    assign sel_ok_s     = sel_valid(8'(bus.sel), NOUT);
    assign switch_req_s = sel_ok_s && (bus.sel != active_sel_r);

    // Intake closes in the very cycle a switch is requested, so no beat can
    // be captured for the old channel once the sequence has started.
    assign bus.bus_ready = (state_r == RUN) && !switch_req_s && hold_ready_s;
    assign accept_s      = bus.bus_valid && bus.bus_ready;

    assign bus.busy       = (state_r != RUN);
    assign bus.active_sel = active_sel_r;

    demux_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_data  (bus.bus_data),
        .in_valid (accept_s),
        .in_ready (hold_ready_s),
        .out_data (hold_data_s),
        .out_valid(hold_valid_s),
        .out_ready(lane_ready_s)
    );

    // Sequencer state, dead-cycle counter and connected channel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RUN;
            cnt_r        <= '0;
            active_sel_r <= '0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            active_sel_r <= active_sel_s;
        end
    end

    // Next-state logic for the break-before-make switch sequence.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        active_sel_s = active_sel_r;
        case (state_r)
            RUN: begin
                if (switch_req_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                // Leave once the buffer is empty or empties on this edge.
                if (!hold_valid_s || lane_ready_s) begin
                    if (TURNAROUND > 0) begin
                        state_s = DEAD;
                        cnt_s   = TA_CNT_W'(TURNAROUND - 1);
                    end else begin
                        state_s = SWITCH;
                    end
                end else begin
                    state_s = DRAIN;
                end
            end
            DEAD: begin
                if (cnt_r == {TA_CNT_W{1'b0}}) begin
                    state_s = SWITCH;
                end else begin
                    cnt_s   = cnt_r - {{(TA_CNT_W-1){1'b0}}, 1'b1};
                    state_s = DEAD;
                end
            end
            SWITCH: begin
                // The request present now wins, even if it changed during
                // DRAIN/DEAD or returned to the original channel.
                if (sel_ok_s) begin
                    active_sel_s = bus.sel;
                end else begin
                    active_sel_s = active_sel_r;
                end
                state_s = RUN;
            end
            default: begin
                state_s = RUN;
            end
        endcase
    end

    // Lane steering: the connected lane carries the held beat, all other
    // lanes read zero (the released equivalent of a floating driver).
    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = '0;
        for (int i = 0; i < NOUT; i++) begin
            if ((SELW'(i) == active_sel_r) && (state_r != DEAD)) begin
                bus.out_valid[i]               = hold_valid_s;
                bus.out_data[i*WIDTH +: WIDTH] = hold_data_s;
            end else begin
                bus.out_valid[i]               = 1'b0;
                bus.out_data[i*WIDTH +: WIDTH] = '0;
            end
        end
    end

`ifdef TRISTATE_DEMUX_XCHECK_EN
    logic err_x_r;

    // Sticky flag for X/Z (contention or undriven) seen on an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_x_r <= 1'b0;
        end else if (accept_s && ((^bus.bus_data) === 1'bx)) begin
            err_x_r <= 1'b1;
        end else begin
            err_x_r <= err_x_r;
        end
    end

    assign bus.err_x = err_x_r;

`ifndef SYNTHESIS
    // Simulation report for an X/Z beat.
    always @(posedge clk) begin
        if (!rst && accept_s && ((^bus.bus_data) === 1'bx)) begin
            $error("tristate_bus_demux: X/Z on bus_data at accepted beat");
        end
    end
`endif
`else
    assign bus.err_x = 1'b0;
`endif

endmodule
